// File: rtl/ro_pkg.sv
// Shared types for the ring-oscillator frequency counter: FSM states and readout byte selects.
// No logic here; imported by the counter and its edge synchronizer.
package ro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        GATE    = 2'd2,
        CAPTURE = 2'd3
    } ro_state_t;

    localparam logic [1:0] BYTE_RES0   = 2'd0;
    localparam logic [1:0] BYTE_RES1   = 2'd1;
    localparam logic [1:0] BYTE_RES2   = 2'd2;
    localparam logic [1:0] BYTE_STATUS = 2'd3;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizes the free-running oscillator into clk and flags its rising edges.
// Latency: SYNC_STAGES+1 cycles from osc_in to edge_det; no backpressure (free-running).
module ro_edge_sync
    import ro_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Inputs at or above f_clk/2 alias silently; nothing here detects it.
    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts ring-oscillator rising edges over a 2^(GATE_MIN_LOG2+gate_sel) clk window and holds the result.
// Latency: done pulses 2^(GATE_MIN_LOG2+gate_sel)+SYNC_STAGES+2 cycles after start; start ignored while busy.
module ro_freq_counter
    import ro_pkg::*;
#(
    parameter int COUNT_W       = 24,
    parameter int GATE_MIN_LOG2 = 10,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       osc_in,
    input  logic       start,
    input  logic [2:0] gate_sel,
    input  logic [1:0] byte_sel,
    output logic [7:0] rd_byte,
    output logic       busy,
    output logic       done,
    output logic       result_valid
);

    localparam int GW = GATE_MIN_LOG2 + 8;
    localparam int AW = $clog2(SYNC_STAGES + 1);

    ro_state_t          state_q, state_d;
    logic [2:0]         gate_sel_q;
    logic [AW-1:0]      arm_cnt_q;
    logic [GW-1:0]      gate_cnt_q;
    logic [GW-1:0]      gate_load;
    logic [COUNT_W-1:0] edge_cnt_q;
    logic [COUNT_W-1:0] result_q;
    logic               overflow_q;
    logic               result_valid_q;
    logic               edge_det;
    logic [23:0]        result_ext;

    ro_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .osc_in  (osc_in),
        .edge_det(edge_det)
    );

    assign gate_load = (GW'(1) << (GATE_MIN_LOG2 + int'(gate_sel_q))) - GW'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     if (arm_cnt_q == '0) state_d = GATE;
            GATE:    if (gate_cnt_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gate_sel_q     <= '0;
            arm_cnt_q      <= '0;
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        gate_sel_q     <= gate_sel;
                        arm_cnt_q      <= AW'(SYNC_STAGES);
                        edge_cnt_q     <= '0;
                        overflow_q     <= 1'b0;
                        result_valid_q <= 1'b0;
                    end
                end
                // Edges seen while the synchronizer flushes belong to stale osc history.
                ARM: begin
                    arm_cnt_q <= arm_cnt_q - 1'b1;
                    if (arm_cnt_q == '0)
                        gate_cnt_q <= gate_load;
                end
                GATE: begin
                    gate_cnt_q <= gate_cnt_q - 1'b1;
                    if (edge_det) begin
                        if (&edge_cnt_q)
                            overflow_q <= 1'b1;
                        else
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    result_q       <= edge_cnt_q;
                    result_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q == ARM) || (state_q == GATE);
    assign done         = (state_q == CAPTURE);
    assign result_valid = result_valid_q;
    assign result_ext   = 24'(result_q);

    always_comb begin
        rd_byte = '0;
        case (byte_sel)
            BYTE_RES0:   rd_byte = result_ext[7:0];
            BYTE_RES1:   rd_byte = result_ext[15:8];
            BYTE_RES2:   rd_byte = result_ext[23:16];
            BYTE_STATUS: rd_byte = {result_valid_q, overflow_q, busy, 5'b0};
            default:     rd_byte = '0;
        endcase
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench: two counters (24-bit and 8-bit) share the stimulus; a monitor checks each done.
module tb_ro_freq_counter;
    import ro_pkg::*;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       osc_in = 1'b0;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic [1:0] byte_sel;
    logic [1:0] drv_sel = 2'd0;
    logic [1:0] mon_sel = 2'd0;
    logic       mon_busy = 1'b0;
    logic [7:0] rd_a, rd_b;
    logic       busy_a, busy_b, done_a, done_b, rv_a, rv_b;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   osc_half = 40;
    logic osc_run = 1'b1;
    logic osc_level = 1'b0;

    typedef struct {
        int cyc;
        int lo;
        int hi;
        int lo_b;
        int hi_b;
        int st_a;
        int st_b;
    } exp_t;

    exp_t sb[$];

    assign byte_sel = mon_busy ? mon_sel : drv_sel;

    ro_freq_counter #(.COUNT_W(24), .GATE_MIN_LOG2(10), .SYNC_STAGES(SYNC)) u_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_sel(gate_sel),
        .byte_sel(byte_sel), .rd_byte(rd_a), .busy(busy_a), .done(done_a), .result_valid(rv_a)
    );

    ro_freq_counter #(.COUNT_W(8), .GATE_MIN_LOG2(10), .SYNC_STAGES(SYNC)) u_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_sel(gate_sel),
        .byte_sel(byte_sel), .rd_byte(rd_b), .busy(busy_b), .done(done_b), .result_valid(rv_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator toggles 3 time units off the clk grid so edges never coincide with posedge.
    initial begin
        #3;
        forever begin
            #(osc_half);
            osc_in = osc_run ? ~osc_in : osc_level;
        end
    end

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // c: cycle in which start is presented; win: gate length; n: hand-computed nominal edge count.
    function automatic exp_t mk(input int c, input int win, input int n, input bit b2b);
        exp_t e;
        e.cyc  = c + win + SYNC + 2;
        e.lo   = (n > 0) ? n - 1 : 0;
        e.hi   = (n > 0) ? n + 1 : 0;
        e.lo_b = (e.lo > 255) ? 255 : e.lo;
        e.hi_b = (e.hi > 255) ? 255 : e.hi;
        e.st_a = b2b ? 'h20 : 'h80;
        e.st_b = b2b ? 'h20 : ((e.lo > 255) ? 'hC0 : 'h80);
        return e;
    endfunction

    // Monitor: on each done, pop the expectation and read the four readout bytes over four cycles.
    initial begin
        exp_t e;
        int   v_a;
        int   v_b;
        forever begin
            @(negedge clk);
            if (!rst && done_a) begin
                chk("expected_done", sb.size() != 0, sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc == e.cyc, cyc, e.cyc);
                    chk("done_b_aligned", done_b == 1'b1, done_b, 1);
                    chk("busy_at_done", busy_a == 1'b0, busy_a, 0);
                    chk("rv_low_at_done", rv_a == 1'b0, rv_a, 0);
                    mon_busy = 1'b1;
                    v_a = 0;
                    v_b = 0;
                    for (int b = 0; b < 3; b++) begin
                        mon_sel = 2'(b);
                        @(negedge clk);
                        v_a |= int'(rd_a) << (8 * b);
                        v_b |= int'(rd_b) << (8 * b);
                        if (b == 0) begin
                            chk("done_one_cycle", done_a == 1'b0, done_a, 0);
                            chk("rv_after_capture", rv_a && rv_b, {rv_a, rv_b}, 3);
                        end
                    end
                    chk_rng("result_a", v_a, e.lo, e.hi);
                    chk_rng("result_b", v_b, e.lo_b, e.hi_b);
                    mon_sel = BYTE_STATUS;
                    @(negedge clk);
                    chk("status_a", int'(rd_a) == e.st_a, rd_a, e.st_a);
                    chk("status_b", int'(rd_b) == e.st_b, rd_b, e.st_b);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start(input int gs, output int c);
        @(negedge clk);
        gate_sel = 3'(gs);
        start    = 1'b1;
        c        = cyc;
        @(negedge clk);
        start    = 1'b0;
        gate_sel = 3'd7;
    endtask

    task automatic wait_drain(input int budget);
        int t0;
        t0 = cyc;
        while ((sb.size() != 0 || mon_busy) && (cyc - t0) < budget)
            @(negedge clk);
        chk("drain_timeout", sb.size() == 0 && !mon_busy, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, busy_a == 1'b0, busy_a, 0);
        chk({tag, "_done"}, done_a == 1'b0, done_a, 0);
        chk({tag, "_rv"}, rv_a == 1'b0, rv_a, 0);
        for (int s = 0; s < 4; s++) begin
            drv_sel = 2'(s);
            #1;
            chk({tag, "_rd_byte"}, rd_a == 8'h00, rd_a, 0);
        end
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Period 8 clk, 1024-cycle window.
        pulse_start(0, c);
        sb.push_back(mk(c, 1024, 128, 1'b0));
        wait_drain(1200);

        // Stuck-high oscillator, 2048-cycle window.
        osc_run   = 1'b0;
        osc_level = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start(1, c);
        sb.push_back(mk(c, 2048, 0, 1'b0));
        wait_drain(2200);
        osc_run = 1'b1;
        repeat (20) @(negedge clk);

        // Second start during GATE must be ignored.
        pulse_start(0, c);
        sb.push_back(mk(c, 1024, 128, 1'b0));
        while (cyc < c + SYNC + 2 + 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(1200);

        // Reset mid-gate, then a fresh measurement.
        pulse_start(0, c);
        sb.push_back(mk(c, 1024, 128, 1'b0));
        while (cyc < c + SYNC + 2 + 500) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_cleared("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start(0, c);
        sb.push_back(mk(c, 1024, 128, 1'b0));
        wait_drain(1200);

        // Back-to-back with start held, period 16 clk.
        osc_half = 80;
        repeat (20) @(negedge clk);
        gate_sel = 3'd0;
        start    = 1'b1;
        c        = cyc;
        sb.push_back(mk(c, 1024, 64, 1'b1));
        sb.push_back(mk(c + 1024 + SYNC + 3, 1024, 64, 1'b0));
        while (cyc < c + 1024 + SYNC + 3 + SYNC + 2 + 50) @(negedge clk);
        start = 1'b0;
        wait_drain(2500);

        // Period 4 clk, 4096-cycle window: saturates the 8-bit counter.
        osc_half = 20;
        repeat (20) @(negedge clk);
        pulse_start(2, c);
        sb.push_back(mk(c, 4096, 1024, 1'b0));
        wait_drain(4300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Digital measurement block for the on-chip ring oscillator: counts rising edges of the oscillator output over a programmable gate window of clk cycles and holds the result for readout.
- Sits beside the ring oscillator macro in the top-level wrapper.
- Takes the oscillator output back in through a digital input pin.
- Presents the result bytewise on uo_out.
- Is the consuming end of the oscillator's output signal.

Parameters:
COUNT_W, 24, width of edge counter and result register (8..24)
GATE_MIN_LOG2, 10, log2 of the shortest gate window in clk cycles
SYNC_STAGES, 2, flops in osc_in synchronizer (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
osc_in  input  1  ring-oscillator output, asynchronous to clk
start  input  1  level; sampled each cycle, starts a measurement when in IDLE
gate_sel  input  3  window = 2^(GATE_MIN_LOG2+gate_sel) clk cycles, latched at start
byte_sel  input  2  selects readout byte
rd_byte  output  8  selected byte of status/result
busy  output  1  high in ARM or GATE
done  output  1  one-cycle pulse when result captured
result_valid  output  1  sticky; set at capture, cleared at next accepted start

Behaviour:
- One clock domain: clk. rst is asynchronous assert, active-high.
- On reset:
  - synchronizer = 0, edge-detect register = 0
  - counters = 0, result = 0, overflow = 0
  - state = IDLE
  - busy = 0, done = 0, result_valid = 0, rd_byte = 0
- Synchronizer: osc_in passes through SYNC_STAGES flops, then one more flop for the previous value.
  - edge = sync & ~prev.
  - Valid only for f_osc < f_clk/2; faster inputs alias (documented limitation, not detected).
- FSM:
  - IDLE: start=1 -> ARM. Latch gate_sel, clear edge_cnt, overflow and result_valid. start=0 -> stay.
  - ARM: lasts SYNC_STAGES+1 cycles; edges ignored while the synchronizer flushes. Then -> GATE and load gate_cnt = 2^(GATE_MIN_LOG2+gate_sel_q) - 1.
  - GATE: exactly 2^(GATE_MIN_LOG2+gate_sel_q) cycles.
    - Each cycle with edge=1, edge_cnt increments.
    - edge_cnt saturates at 2^COUNT_W-1 and sets overflow (sticky until next start).
    - gate_cnt decrements; on the cycle gate_cnt==0 -> CAPTURE. An edge on that final cycle is counted.
  - CAPTURE: one cycle.
    - result <= edge_cnt; result_valid <= 1; done = 1.
    - The edge detector is not sampled in this cycle.
    - -> IDLE.
- start while in ARM/GATE/CAPTURE is ignored; gate_sel changes after start have no effect.
- start held high continuously re-arms on the cycle after CAPTURE (IDLE seen for 1 cycle); back-to-back measurements are allowed.
- gate_cnt width is GATE_MIN_LOG2+8 bits.
- Counting resolution ±1 edge by sampling phase.
- Readout is combinational from registered sources:
  - result is zero-extended to 24 bits.
  - byte_sel 0 -> result[7:0], 1 -> result[15:8], 2 -> result[23:16].
  - byte_sel 3 -> {result_valid, overflow, busy, 5'b0}.
  - result holds its previous value during a new measurement until the next CAPTURE.
- Reset asserted mid-measurement: immediate return to reset state; no done pulse; result cleared.
- osc_in stuck at 0 or 1: measurement completes normally with result 0.

Decomposition:
- Shared package ro_pkg: FSM state enum (IDLE, ARM, GATE, CAPTURE) and readout byte index constants (BYTE_RES0..BYTE_STATUS).
- One natural sub-module: ro_edge_sync. It contains the SYNC_STAGES synchronizer, the prev flop and the edge output, with its own clk/rst.
- Top wrapper instantiation (pin routing to ui_in/uo_out) is out of scope.

Test Plan:
- Period test: osc_in period 8 clk (async phase), gate_sel=0 (1024 cycles), start pulse -> done after 1024+SYNC_STAGES+2 cycles; result=128±1; overflow=0; byte_sel=3 reads 0x80.
- Saturation: COUNT_W=8, osc period 4 clk, gate_sel=2 (4096 cycles) -> result=255, overflow=1; byte_sel=3 reads 0xC0; byte_sel=0 reads 0xFF.
- Stuck input: osc_in=1 constant, gate_sel=1 -> done after 2048+SYNC_STAGES+2 cycles; result=0; result_valid=1.
- Start ignored: second start pulse at GATE cycle 100 -> exactly one done pulse; result unchanged vs single-start run.
- Reset mid-gate: rst at GATE cycle 500 -> next cycle busy=0, result_valid=0, rd_byte=0 for all byte_sel; a fresh start then yields a correct count.
- Back-to-back: start held high, osc period 16, gate_sel=0 -> done pulses spaced 1024+SYNC_STAGES+3 cycles apart; each result 64±1; result_valid low only during ARM/GATE.
